// File: rtl/omsp_sha512_msg_packer.sv
// SHA-512 message packer: packs 8/16-bit writes into big-endian 64-bit words,
// pads with 0x80/zeros plus the bit length, then streams the digest back.
//   state     | meaning
//   IDLE      | waiting for a start write
//   ACCEPT    | taking message bytes
//   PAD_ONE   | pushing the 0x80 marker byte
//   PAD_ZERO  | zero fill up to byte 112 of the block
//   LEN_HI    | upper length word (always zero)
//   LEN_LO    | bit-length word, last of its block
//   WAIT_CORE | draining the last word, waiting for compression
//   DONE      | digest available
//   READ      | 32-cycle digest readout
module omsp_sha512_msg_packer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   cmd_in,
  input  logic [15:0]  data,
  input  logic         data_size,
  output logic [15:0]  hash,
  output logic         busy,
  output logic         ready_for_data,
  output logic [63:0]  core_word,
  output logic         core_word_valid,
  input  logic         core_word_ready,
  output logic         core_first,
  output logic         core_block_last,
  input  logic         core_busy,
  input  logic [511:0] core_digest
);

  typedef enum logic [3:0] {
    IDLE, ACCEPT, PAD_ONE, PAD_ZERO, LEN_HI, LEN_LO, WAIT_CORE, DONE, READ
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] stage_buf, stage_nxt, load_word, direct_word;
  logic [3:0]  fill, fill_nxt;
  logic [3:0]  word_idx, word_idx_nxt;
  logic [31:0] byte_count;
  logic [6:0]  block_byte, block_inc;
  logic [4:0]  read_idx;
  logic        first_done, handshake, load, direct_load;
  logic        clear_ctx, start_read, msg_push;
  logic [1:0]  push_cnt;
  logic [7:0]  push_b0, push_b1;
  logic        cmd_write, cmd_read, cmd_end;

  assign cmd_write = (cmd_in == 2'b10);
  assign cmd_read  = (cmd_in == 2'b01);
  assign cmd_end   = (cmd_in[1] == cmd_in[0]);

  assign handshake      = core_word_valid & core_word_ready;
  assign ready_for_data = (state == ACCEPT) && !core_word_valid;
  assign busy           = (state != IDLE) && (state != DONE);
  // Word 0 of the digest sits at the top, so invert the index to address it.
  assign hash = ((state == DONE) || (state == READ)) ?
                core_digest[{~read_idx, 4'b0000} +: 16] : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    push_cnt    = 2'd0;
    push_b0     = 8'h00;
    push_b1     = 8'h00;
    msg_push    = 1'b0;
    direct_load = 1'b0;
    direct_word = 64'h0;
    clear_ctx   = 1'b0;
    start_read  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_write) begin
          clear_ctx = 1'b1;
          state_nxt = ACCEPT;
        end
      end
      ACCEPT: begin
        if (!core_word_valid) begin
          if (cmd_write) begin
            msg_push = 1'b1;
            push_cnt = data_size ? 2'd2 : 2'd1;
            push_b0  = data_size ? data[15:8] : data[7:0];
            push_b1  = data[7:0];
          end else if (cmd_end) begin
            state_nxt = PAD_ONE;
          end
        end
      end
      PAD_ONE: begin
        if (!core_word_valid) begin
          push_cnt  = 2'd1;
          push_b0   = 8'h80;
          state_nxt = PAD_ZERO;
        end
      end
      PAD_ZERO: begin
        if ((block_byte == 7'd112) && (fill == 4'd0)) begin
          state_nxt = LEN_HI;
        end else if (!core_word_valid) begin
          push_cnt = 2'd1;
        end
      end
      LEN_HI: begin
        if (!core_word_valid) begin
          direct_load = 1'b1;
          state_nxt   = LEN_LO;
        end
      end
      LEN_LO: begin
        if (!core_word_valid) begin
          direct_load = 1'b1;
          direct_word = {29'b0, byte_count, 3'b000};
          state_nxt   = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        if (!core_word_valid && !core_busy) state_nxt = DONE;
      end
      DONE: begin
        if (cmd_write) begin
          clear_ctx = 1'b1;
          state_nxt = ACCEPT;
        end else if (cmd_read) begin
          start_read = 1'b1;
          state_nxt  = READ;
        end
      end
      READ: begin
        if (read_idx == 5'd31) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A 16-bit write landing at fill 7 completes the word with its high byte
  // and leaves the low byte as the first byte of the next word.
  always_comb begin
    stage_nxt = stage_buf;
    fill_nxt  = fill;
    load      = 1'b0;
    load_word = 64'h0;
    if (push_cnt == 2'd1) begin
      stage_nxt = {stage_buf[55:0], push_b0};
      if (fill == 4'd7) begin
        load      = 1'b1;
        load_word = stage_nxt;
        fill_nxt  = 4'd0;
      end else begin
        fill_nxt = fill + 4'd1;
      end
    end else if (push_cnt == 2'd2) begin
      stage_nxt = {stage_buf[47:0], push_b0, push_b1};
      if (fill == 4'd6) begin
        load      = 1'b1;
        load_word = stage_nxt;
        fill_nxt  = 4'd0;
      end else if (fill == 4'd7) begin
        load      = 1'b1;
        load_word = {stage_buf[55:0], push_b0};
        fill_nxt  = 4'd1;
      end else begin
        fill_nxt = fill + 4'd2;
      end
    end
    if (direct_load) begin
      load      = 1'b1;
      load_word = direct_word;
    end
  end

  assign word_idx_nxt = word_idx + {3'b000, handshake};
  assign block_inc    = direct_load ? 7'd8 : {5'b00000, push_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_buf       <= 64'h0;
      fill            <= 4'd0;
      byte_count      <= 32'd0;
      block_byte      <= 7'd0;
      word_idx        <= 4'd0;
      first_done      <= 1'b0;
      core_word       <= 64'h0;
      core_word_valid <= 1'b0;
      core_first      <= 1'b0;
      core_block_last <= 1'b0;
      read_idx        <= 5'd0;
    end else begin
      if (clear_ctx) begin
        stage_buf  <= 64'h0;
        fill       <= 4'd0;
        byte_count <= 32'd0;
        block_byte <= 7'd0;
        word_idx   <= 4'd0;
        first_done <= 1'b0;
      end else begin
        stage_buf  <= stage_nxt;
        fill       <= fill_nxt;
        block_byte <= block_byte + block_inc;
        word_idx   <= word_idx_nxt;
        first_done <= first_done | handshake;
        if (msg_push) byte_count <= byte_count + {30'b0, push_cnt};
      end
      if (load) begin
        core_word       <= load_word;
        core_word_valid <= 1'b1;
        core_first      <= !(first_done | handshake);
        core_block_last <= (word_idx_nxt == 4'd15);
      end else if (handshake) begin
        core_word_valid <= 1'b0;
        core_first      <= 1'b0;
        core_block_last <= 1'b0;
      end
      if (start_read)          read_idx <= 5'd0;
      else if (state == READ)  read_idx <= read_idx + 5'd1;
    end
  end

endmodule

// File: tb/tb_omsp_sha512_msg_packer.sv
// Bench for omsp_sha512_msg_packer: table of messages checked word-by-word
// against a reference SHA-512 padding model, plus readout and reset sequences.
module tb_omsp_sha512_msg_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   cmd_in = 2'b00;
  logic [15:0]  data = 16'h0;
  logic         data_size = 1'b0;
  logic [15:0]  hash;
  logic         busy, ready_for_data;
  logic [63:0]  core_word;
  logic         core_word_valid;
  logic         core_word_ready = 1'b1;
  logic         core_first, core_block_last;
  logic         core_busy = 1'b0;
  logic [511:0] core_digest = '0;

  always #5 clk = ~clk;

  omsp_sha512_msg_packer dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .data(data), .data_size(data_size),
    .hash(hash), .busy(busy), .ready_for_data(ready_for_data),
    .core_word(core_word), .core_word_valid(core_word_valid),
    .core_word_ready(core_word_ready), .core_first(core_first),
    .core_block_last(core_block_last), .core_busy(core_busy),
    .core_digest(core_digest)
  );

  typedef struct { logic [63:0] word; logic first; logic last; } exp_t;
  typedef struct {
    int nbytes; int mode; int kind; bit bp; bit rnd;
    int exp_words; int chk_idx; logic [63:0] chk_word;
  } vec_t;

  exp_t        exp_q[$];
  logic [63:0] recv[$];
  logic [7:0]  msg[$];
  vec_t        vecs[9];
  int          n_cmp = 0, n_bad = 0;
  bit          hold_ready = 0, rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not reached, expected it within the cycle budget", name);
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n && core_word_valid && core_word_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_word: got 0x%h, expected no further word", core_word);
      end else begin
        e = exp_q.pop_front();
        check("core_word", core_word, e.word);
        check("core_first", {63'b0, core_first}, {63'b0, e.first});
        check("core_block_last", {63'b0, core_block_last}, {63'b0, e.last});
        recv.push_back(core_word);
      end
    end
    @(posedge clk);
    #1;
    core_word_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  function automatic logic [7:0] pat_byte(input int kind, input int i);
    logic [31:0] t;
    case (kind)
      0:       t = 32'h61 + i;
      1:       t = 32'hA5;
      default: t = i * 37 + 5;
    endcase
    return t[7:0];
  endfunction

  // Reference padding: 0x80, zeros to 112 mod 128, 128-bit big-endian bit length.
  task automatic model_push();
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    exp_t        e;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 128) != 112) p.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int k = 0; k < 8; k++) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
    for (int w = 0; w < p.size() / 8; w++) begin
      e.word = 64'h0;
      for (int k = 0; k < 8; k++) e.word = {e.word[55:0], p[8*w+k]};
      e.first = (w == 0);
      e.last  = ((w % 16) == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_msg(input int vi);
    vec_t        v;
    int          i, guard;
    bit          w, acc, bp_done;
    logic [63:0] held;
    v = vecs[vi];
    msg.delete();
    for (int k = 0; k < v.nbytes; k++) msg.push_back(pat_byte(v.kind, k));
    model_push();
    recv.delete();
    rand_ready = v.rnd;
    hold_ready = v.bp;
    if (v.bp) core_word_ready = 1'b0;
    core_busy = 1'b1;
    cmd_in = 2'b10; data = 16'hFFFF; data_size = 1'b1;
    tick();
    i = 0; guard = 0; bp_done = 0;
    while (i < v.nbytes && guard < 4000) begin
      w = ((v.mode == 1) || (v.mode == 2 && i > 0)) && (i + 1 < v.nbytes);
      cmd_in = 2'b10;
      data_size = w;
      data = w ? {msg[i], msg[i+1]} : {8'h5A, msg[i]};
      acc = ready_for_data;
      tick();
      guard++;
      if (acc) i += w ? 2 : 1;
      if (v.bp && !bp_done && i == 8) begin
        bp_done = 1;
        check("bp_ready_low", {63'b0, ready_for_data}, 64'd0);
        held = core_word;
        for (int k = 0; k < 3; k++) begin
          cmd_in = 2'b10; data = 16'h1111; data_size = 1'b1;
          tick();
        end
        check("bp_word_stable", core_word, held);
        check("bp_valid_held", {63'b0, core_word_valid}, 64'd1);
        check("bp_word_value", held, exp_q[0].word);
        hold_ready = 0;
      end
    end
    if (i < v.nbytes) fail_now("write_accept");
    cmd_in = (v.kind == 2) ? 2'b11 : 2'b00;
    data_size = 1'b0;
    guard = 0;
    while (!ready_for_data && guard < 100) begin tick(); guard++; end
    tick();
    cmd_in = 2'b00;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin tick(); guard++; end
    if (exp_q.size() != 0) fail_now("word_drain");
    check("words_received", 64'(recv.size()), 64'(v.exp_words));
    if (v.chk_idx < recv.size()) check("table_word", recv[v.chk_idx], v.chk_word);
    else fail_now("table_word_present");
    tick(); tick();
    check("busy_while_core_busy", {63'b0, busy}, 64'd1);
    core_busy = 1'b0;
    guard = 0;
    while (busy && guard < 10) begin tick(); guard++; end
    check("done_after_core_busy", {63'b0, busy}, 64'd0);
    rand_ready = 0;
  endtask

  initial begin
    //            nbytes mode kind bp rnd words idx word
    vecs[0] = '{  0, 0, 0, 1'b0, 1'b0, 16,  0, 64'h8000_0000_0000_0000};
    vecs[1] = '{  3, 0, 0, 1'b0, 1'b0, 16,  0, 64'h6162_6380_0000_0000};
    vecs[2] = '{  3, 0, 0, 1'b0, 1'b1, 16, 15, 64'h0000_0000_0000_0018};
    vecs[3] = '{112, 1, 1, 1'b0, 1'b0, 32, 14, 64'h8000_0000_0000_0000};
    vecs[4] = '{112, 1, 1, 1'b0, 1'b1, 32, 31, 64'h0000_0000_0000_0380};
    vecs[5] = '{ 17, 2, 0, 1'b0, 1'b0, 16,  1, 64'h696A_6B6C_6D6E_6F70};
    vecs[6] = '{111, 0, 2, 1'b0, 1'b1, 16, 15, 64'h0000_0000_0000_0378};
    vecs[7] = '{ 16, 1, 1, 1'b1, 1'b0, 16,  0, 64'hA5A5_A5A5_A5A5_A5A5};
    vecs[8] = '{120, 1, 2, 1'b0, 1'b1, 32, 30, 64'h0000_0000_0000_0000};

    #12;
    check("rst_hash", {48'b0, hash}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {63'b0, ready_for_data}, 64'd0);
    check("rst_core_word", core_word, 64'd0);
    check("rst_valid", {63'b0, core_word_valid}, 64'd0);
    check("rst_first", {63'b0, core_first}, 64'd0);
    check("rst_last", {63'b0, core_block_last}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int vi = 0; vi < 9; vi++) run_msg(vi);

    // Digest readout: word k of the digest holds the value k.
    for (int k = 0; k < 32; k++) core_digest[16*(31-k) +: 16] = 16'(k);
    cmd_in = 2'b01;
    tick();
    cmd_in = 2'b00;
    for (int k = 0; k < 32; k++) begin
      check("read_hash", {48'b0, hash}, 64'(k));
      check("read_busy", {63'b0, busy}, 64'd1);
      tick();
    end
    check("read_end_busy", {63'b0, busy}, 64'd0);
    check("read_end_hash", {48'b0, hash}, 64'd0);

    // Reset while stalled in zero padding.
    hold_ready = 1;
    core_word_ready = 1'b0;
    cmd_in = 2'b10; data_size = 1'b0; data = 16'h0;
    tick();
    for (int k = 0; k < 3; k++) begin
      data = {8'h00, pat_byte(0, k)};
      tick();
    end
    cmd_in = 2'b00;
    for (int k = 0; k < 7; k++) tick();
    check("prereset_valid", {63'b0, core_word_valid}, 64'd1);
    check("prereset_busy", {63'b0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'b0, core_word_valid}, 64'd0);
    check("async_rst_word", core_word, 64'd0);
    check("async_rst_busy", {63'b0, busy}, 64'd0);
    check("async_rst_first", {63'b0, core_first}, 64'd0);
    check("async_rst_ready", {63'b0, ready_for_data}, 64'd0);
    tick();
    rst_n = 1'b1;
    hold_ready = 0;
    exp_q.delete();
    run_msg(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/omsp_sha512_msg_packer.md
# omsp_sha512_msg_packer

Responder side of the SHA-512 command interface used by the Sancus hashing controllers. It accepts a message as a stream of 8-/16-bit writes, packs it big-endian into 64-bit words, and applies SHA-512 padding plus a 128-bit length field. The packed words are fed to the SHA-512 compression core over a valid/ready handshake. Once the core finishes, the 512-bit digest is streamed back to the initiator as 32 16-bit words.

## Interface
- No parameters.
- Reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_in  in  2  command:
  - 10 = write/start.
  - 01 = start digest readout.
  - 00 = no-op / end-of-message.
  - 11 = reserved, treated as 00.
- data  in  16  write data.
- data_size  in  1  1 = 16-bit word (data[15:8] is the first byte); 0 = byte (data[7:0]).
- hash  out  16  digest word; 0 outside DONE/READ.
- busy  out  1  high in every state except IDLE and DONE.
- ready_for_data  out  1  write accepted this cycle if cmd_in=10.
- core_word  out  64  packed message word, big-endian.
- core_word_valid  out  1  core_word is valid.
- core_word_ready  in  1  core accepts core_word this cycle.
- core_first  out  1  core_word is word 0 of block 0; core reloads the SHA-512 IV.
- core_block_last  out  1  core_word is word 15 of its block.
- core_busy  in  1  core is compressing.
- core_digest  in  512  H0..H7; H0 is in [511:448].

## Operation
- **States:** IDLE, ACCEPT, PAD_ONE, PAD_ZERO, LEN_HI, LEN_LO, WAIT_CORE, DONE, READ.
- **IDLE/DONE:**
  - cmd_in=10 → ACCEPT. That cycle's data is ignored. Clears byte_count (32 bits), fill (0..8), block_byte (7 bits) and the first flag.
  - DONE with cmd_in=01 → READ with read_idx=0.
  - All other commands are ignored.
- **ACCEPT:**
  - ready_for_data = !core_word_valid.
  - Write accepted: cmd_in=10 and ready_for_data=1. It shifts 1 or 2 bytes into the 64-bit staging buffer.
  - When fill reaches 8, the buffer moves to core_word and core_word_valid is set.
  - 16-bit write at fill=7: the high byte completes the word; the low byte becomes fill=1 of the next word.
  - byte_count and block_byte advance by the bytes accepted.
  - cmd_in=00 with ready_for_data=1 = end of message → PAD_ONE.
  - cmd_in=00 with ready_for_data=0 is a stall and has no effect.
  - cmd_in=10 with ready_for_data=0 is dropped; the initiator re-issues it.
- **PAD_ONE:** pushes byte 0x80 when !core_word_valid, then → PAD_ZERO.
- **PAD_ZERO:**
  - Pushes one 0x00 byte per cycle when !core_word_valid, until block_byte=112 and fill=0.
  - If block_byte=112 on entry, no zero bytes are pushed.
  - block_byte wraps 127→0.
- **LEN_HI:** emits word 0 when !core_word_valid.
- **LEN_LO:**
  - Emits {29'b0, byte_count, 3'b0} (the bit length), flagged core_block_last.
  - Then → WAIT_CORE.
- **Core handshake:**
  - core_word_valid holds, with core_word stable, until core_word_ready.
  - core_block_last = (word index within block == 15). The word index is a 4-bit counter, incremented per handshake.
  - core_first is high on the first handshake word only.
- **WAIT_CORE:** waits for !core_word_valid && !core_busy → DONE.
- **READ:**
  - hash = core_digest[511-16*read_idx -: 16], i.e. MSW first.
  - read_idx increments every cycle.
  - After read_idx=31 → IDLE.
- **Byte counter:** byte_count wraps at 2^32; upper 93 length bits are always 0.

## Timing
- **Reset values:**
  - state IDLE.
  - hash=0, busy=0, ready_for_data=0.
  - core_word=0, core_word_valid=0, core_first=0, core_block_last=0.
  - All counters 0.
- **Reset mid-operation:** returns to IDLE immediately. core_word_valid drops asynchronously; a partially sent block is abandoned.
- **Registered outputs:** ready_for_data, busy and hash are decoded from registered state only; none depend combinationally on cmd_in.
- **Write acceptance:** the write is sampled on the clk edge where cmd_in=10 && ready_for_data.
- **Word latency:** 16-bit writes produce core_word_valid on the cycle after the 4th accepted write.
- **Simultaneous events:**
  - core_word_ready and a buffer fill in the same cycle: the new word loads and valid stays high (back-to-back words).
  - In that same cycle, ready_for_data in the next cycle follows the new valid.
- **Padding throughput:** 1 byte per cycle when unstalled.
- **Readout:** READ is exactly 32 cycles. busy is high during READ. hash is valid in the same cycle read_idx is applied.

## Test plan
- **Empty message:** cmd 10, then cmd 00 → 16 words:
  - word0 = 0x8000_0000_0000_0000.
  - words 1–15 = 0.
  - core_first on word0 only; core_block_last on word15.
  - DONE after core_busy falls.
- **"abc" as bytes:** 0x61, 0x62, 0x63, then end →
  - word0 = 0x6162_6380_0000_0000.
  - word15 = 0x0000_0000_0000_0018.
- **112-byte message:** 56 16-bit writes of 0xA5A5 → 2 blocks (32 words):
  - word14 = 0x8000_0000_0000_0000.
  - word30 = 0.
  - word31 = 0x380.
- **Backpressure:** hold core_word_ready=0 → ready_for_data drops after the 4th 16-bit write. A cmd 10 while ready is low is not counted, and byte_count is unchanged. core_word is stable until ready rises.
- **Readout:** core_digest = {32 words 0x0000..0x001F}, cmd 01 in DONE → hash = 0x0000 … 0x001F on consecutive cycles, then IDLE with busy=0.
- **Reset mid-message:** assert rst_n=0 during PAD_ZERO → all outputs take their reset values asynchronously. A new message afterwards hashes correctly with core_first=1.
